// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tpu_pkg
// Description : Shared types for the TPU slot timer / slot tracker pair:
//               slot number width and type, tracker state encoding and a
//               slot-successor helper (wraps at the end of the frame).
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int SLOT_W = 8;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } trk_state_t;

    // Next slot in the frame; width-limited add wraps 2**SLOT_W-1 -> 0.
    function automatic slot_t slot_next(input slot_t s);
        return s + 1'b1;
    endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tpu_wdog.sv
`default_nettype none
// ============================================================================
// Module      : tpu_wdog
// Description : Loadable up-counter used as a tick watchdog. Counts while
//               i_en is high; o_expire is a combinational pulse on the cycle
//               the count would pass LIMIT-1 with no clear pending, after
//               which the counter restarts from zero.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clr           - restart count from zero (beats i_en)
//               i_load/i_load_val - preset count (beats i_clr)
//               i_en            - count enable
//               o_expire        - expiry strobe
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_wdog #(
    parameter int WDOG_W = 17,
    parameter int LIMIT  = 40000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [WDOG_W-1:0] i_load_val,
    input  logic              i_en,
    output logic              o_expire
);

    localparam logic [WDOG_W-1:0] c_LAST = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] r_cnt;

    // A clear or load in the same cycle means activity was seen: no expiry.
    assign o_expire = i_en && !i_clr && !i_load && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : tpu_wdog
`default_nettype wire

// File: rtl/tpu_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tpu_slot_tracker
// Description : Receive-side slot tracker. Follows the TPU slot tick / slot
//               number, acquires lock after LOCK_CNT consecutive in-sequence
//               ticks, and while locked opens TX/RX slot windows, pulses
//               FRAME_START at slot 0 and raises a sticky slot interrupt.
//               Out-of-sequence ticks (SLIP) and tick loss (LOSS) drop lock.
// Ports       : SYS_CLK, RSTTPU             - clock, sync active-high reset
//               SLOT_TICK, SLOT_NUM         - TPU slot strobe and number
//               TXSLOT_EN/TX_SLOT           - TX window enable and slot
//               RXSLOT_EN/RX_SLOT           - RX window enable and slot
//               TIMERINTMSK, INTCLR         - interrupt enable and clear
//               TX_WIN, RX_WIN              - slot windows (registered)
//               FRAME_START, SLIP, LOSS, COLLIDE - one-cycle status pulses
//               INTFLAG                     - sticky slot interrupt
//               LOCKED                      - tracker is locked
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_slot_tracker #(
    parameter int LOCK_CNT = 4,
    parameter int WDOG_W   = 17,
    parameter int WDOG_CYC = 40000
) (
    input  logic                       SYS_CLK,
    input  logic                       RSTTPU,
    input  logic                       SLOT_TICK,
    input  logic [tpu_pkg::SLOT_W-1:0] SLOT_NUM,
    input  logic                       TXSLOT_EN,
    input  logic                       RXSLOT_EN,
    input  logic [tpu_pkg::SLOT_W-1:0] TX_SLOT,
    input  logic [tpu_pkg::SLOT_W-1:0] RX_SLOT,
    input  logic                       TIMERINTMSK,
    input  logic                       INTCLR,
    output logic                       TX_WIN,
    output logic                       RX_WIN,
    output logic                       FRAME_START,
    output logic                       INTFLAG,
    output logic                       LOCKED,
    output logic                       SLIP,
    output logic                       LOSS,
    output logic                       COLLIDE
);

    import tpu_pkg::*;

    localparam int                c_GC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [c_GC_W-1:0] c_LOCK    = c_GC_W'(LOCK_CNT);
    localparam logic [c_GC_W-1:0] c_LOCK_M1 = c_GC_W'(LOCK_CNT - 1);
    localparam logic [c_GC_W-1:0] c_ONE     = c_GC_W'(1);

    // The LOCKED output port shadows the enum literal of the same name, so
    // the state value is always referenced through the package scope.
    trk_state_t        r_state,    w_state_nxt;
    logic [c_GC_W-1:0] r_good_cnt, w_good_nxt;
    slot_t             r_expected;
    logic              r_tx_win,   w_tx_nxt;
    logic              r_rx_win,   w_rx_nxt;
    logic              r_fs,       w_fs_nxt;
    logic              r_slip,     w_slip_nxt;
    logic              r_loss,     w_loss_nxt;
    logic              r_col,      w_col_nxt;
    logic              r_intflag;

    logic w_is_locked;
    logic w_in_seq;
    logic w_tx_hit;
    logic w_rx_req;
    logic w_wdog_exp;
    logic w_int_set;

    assign w_is_locked = (r_state == tpu_pkg::LOCKED);
    assign w_in_seq    = (SLOT_NUM == r_expected);
    assign w_tx_hit    = TXSLOT_EN && (SLOT_NUM == TX_SLOT);
    assign w_rx_req    = RXSLOT_EN && (SLOT_NUM == RX_SLOT);

    // Watchdog runs only while locked and restarts on every tick, so a tick
    // arriving on the last permitted cycle suppresses the expiry.
    tpu_wdog #(
        .WDOG_W (WDOG_W),
        .LIMIT  (WDOG_CYC)
    ) u_wdog (
        .clk        (SYS_CLK),
        .rst        (RSTTPU),
        .i_clr      (SLOT_TICK || !w_is_locked),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_is_locked),
        .o_expire   (w_wdog_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        // Between ticks an open window only closes if its enable drops.
        w_tx_nxt    = r_tx_win && TXSLOT_EN && w_is_locked;
        w_rx_nxt    = r_rx_win && RXSLOT_EN && w_is_locked;
        w_fs_nxt    = 1'b0;
        w_slip_nxt  = 1'b0;
        w_loss_nxt  = 1'b0;
        w_col_nxt   = 1'b0;

        case (r_state)
            HUNT: begin
                if (SLOT_TICK) begin
                    // good_cnt==0 right after reset: any first tick gives 1.
                    if (w_in_seq || (r_good_cnt == '0)) begin
                        if (r_good_cnt == c_LOCK_M1) begin
                            w_state_nxt = tpu_pkg::LOCKED;
                            w_good_nxt  = c_LOCK;
                        end else begin
                            w_good_nxt  = r_good_cnt + 1'b1;
                        end
                    end else begin
                        w_good_nxt = c_ONE;
                    end
                end
            end
            tpu_pkg::LOCKED: begin
                if (SLOT_TICK) begin
                    if (w_in_seq) begin
                        w_tx_nxt  = w_tx_hit;
                        w_rx_nxt  = w_rx_req && !w_tx_hit;
                        w_col_nxt = w_tx_hit && w_rx_req;
                        w_fs_nxt  = (SLOT_NUM == '0);
                    end else begin
                        // The slipping tick is the first tick of the new hunt.
                        w_state_nxt = HUNT;
                        w_good_nxt  = c_ONE;
                        w_slip_nxt  = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_rx_nxt    = 1'b0;
                    end
                end else if (w_wdog_exp) begin
                    w_state_nxt = LOST;
                    w_loss_nxt  = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_rx_nxt    = 1'b0;
                end
            end
            LOST: begin
                if (SLOT_TICK) begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = c_ONE;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Interrupt fires on a window's rising edge; set beats a same-cycle clear.
    assign w_int_set = TIMERINTMSK &&
                       ((w_tx_nxt && !r_tx_win) || (w_rx_nxt && !r_rx_win));

    always_ff @(posedge SYS_CLK) begin
        if (RSTTPU) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_expected <= '0;
            r_tx_win   <= 1'b0;
            r_rx_win   <= 1'b0;
            r_fs       <= 1'b0;
            r_slip     <= 1'b0;
            r_loss     <= 1'b0;
            r_col      <= 1'b0;
            r_intflag  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            if (SLOT_TICK) begin
                r_expected <= slot_next(SLOT_NUM);
            end
            r_tx_win   <= w_tx_nxt;
            r_rx_win   <= w_rx_nxt;
            r_fs       <= w_fs_nxt;
            r_slip     <= w_slip_nxt;
            r_loss     <= w_loss_nxt;
            r_col      <= w_col_nxt;
            if (w_int_set) begin
                r_intflag <= 1'b1;
            end else if (INTCLR) begin
                r_intflag <= 1'b0;
            end
        end
    end

    assign TX_WIN      = r_tx_win;
    assign RX_WIN      = r_rx_win;
    assign FRAME_START = r_fs;
    assign INTFLAG     = r_intflag;
    assign LOCKED      = w_is_locked;
    assign SLIP        = r_slip;
    assign LOSS        = r_loss;
    assign COLLIDE     = r_col;

endmodule : tpu_slot_tracker
`default_nettype wire

// File: tb/tb_tpu_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_slot_tracker
// Description : Self-checking bench for tpu_slot_tracker: a cycle table,
//               directed multi-cycle sequences and randomized ticks, all
//               compared against a behavioural model of the tracker rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_slot_tracker;

    localparam int LOCK = 4;
    localparam int WDOG = 60;

    logic       clk = 1'b0;
    logic       rst, tick, txen, rxen, msk, clr;
    logic [7:0] slot, txs, rxs;
    logic       tx_win, rx_win, frame_start, intflag, locked, slip, loss, collide;

    tpu_slot_tracker #(
        .LOCK_CNT (LOCK),
        .WDOG_W   (17),
        .WDOG_CYC (WDOG)
    ) dut (
        .SYS_CLK     (clk),
        .RSTTPU      (rst),
        .SLOT_TICK   (tick),
        .SLOT_NUM    (slot),
        .TXSLOT_EN   (txen),
        .RXSLOT_EN   (rxen),
        .TX_SLOT     (txs),
        .RX_SLOT     (rxs),
        .TIMERINTMSK (msk),
        .INTCLR      (clr),
        .TX_WIN      (tx_win),
        .RX_WIN      (rx_win),
        .FRAME_START (frame_start),
        .INTFLAG     (intflag),
        .LOCKED      (locked),
        .SLIP        (slip),
        .LOSS        (loss),
        .COLLIDE     (collide)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    bit m_locked, m_lost;
    int m_run;        // consecutive in-sequence ticks while hunting
    int m_exp;        // slot number the next tick should carry
    int m_last;       // cycle index of the last accepted tick while locked
    int m_cyc = 0;    // index of the cycle currently presented to the DUT
    bit e_tx, e_rx, e_fs, e_int, e_slip, e_loss, e_col;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Computes the outputs that must be visible after the coming clock edge.
    task automatic model_step();
        bit n_tx, n_rx, inseq, hit, req;
        if (rst) begin
            m_locked = 0; m_lost = 0; m_run = 0; m_exp = 0;
            {e_tx, e_rx, e_fs, e_int, e_slip, e_loss, e_col} = '0;
        end else begin
            n_tx = e_tx && txen && m_locked;
            n_rx = e_rx && rxen && m_locked;
            e_fs = 0; e_slip = 0; e_loss = 0; e_col = 0;
            if (tick) begin
                inseq = (int'(slot) == m_exp);
                m_exp = (int'(slot) + 1) % 256;
                if (m_locked) begin
                    if (inseq) begin
                        m_last = m_cyc;
                        hit  = txen && (slot == txs);
                        req  = rxen && (slot == rxs);
                        n_tx = hit;
                        n_rx = req && !hit;
                        e_col = hit && req;
                        e_fs  = (slot == 8'd0);
                    end else begin
                        e_slip = 1; m_locked = 0; m_run = 1; n_tx = 0; n_rx = 0;
                    end
                end else if (m_lost) begin
                    m_lost = 0; m_run = 1;
                end else begin
                    m_run = inseq ? m_run + 1 : 1;
                    if (m_run == LOCK) begin
                        m_locked = 1; m_last = m_cyc;
                    end
                end
            end else if (m_locked && (m_cyc - m_last == WDOG)) begin
                e_loss = 1; m_locked = 0; m_lost = 1; n_tx = 0; n_rx = 0;
            end
            if (msk && ((n_tx && !e_tx) || (n_rx && !e_rx))) e_int = 1;
            else if (clr) e_int = 0;
            e_tx = n_tx;
            e_rx = n_rx;
        end
        m_cyc++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("model", {24'd0, tx_win, rx_win, frame_start, intflag, locked, slip, loss, collide},
            {24'd0, e_tx, e_rx, e_fs, e_int, m_locked, e_slip, e_loss, e_col});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_tick(input int s);
        tick = 1'b1;
        slot = 8'(s);
        cycle();
        tick = 1'b0;
    endtask

    task automatic rand_ctl();
        clr = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 19) == 0) txen = 1'b0;
        if ($urandom_range(0, 19) == 0) rxen = 1'b0;
    endtask

    // ---------------- cycle table ----------------
    // exp bit order: {TX_WIN, RX_WIN, FRAME_START, INTFLAG, LOCKED, SLIP, LOSS, COLLIDE}
    typedef struct {
        bit       rst;
        bit       tick;
        int       slot;
        bit       txen;
        bit       rxen;
        int       txs;
        int       rxs;
        bit       msk;
        bit       clr;
        bit [7:0] exp;
    } row_t;

    row_t tbl[13];
    int   gap, r, s, gs, n, fs_cnt, slip_cnt;

    initial begin
        #3_000_000;
        $display("FAIL sim_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        //          rst tick slot txen rxen txs  rxs  msk clr  exp
        tbl[0]  = '{1, 0,   0,   0,   0,   0,   0,   0,  0,  8'b0000_0000};
        tbl[1]  = '{0, 1, 116,   1,   1, 119, 119,   1,  0,  8'b0000_0000};
        tbl[2]  = '{0, 1, 117,   1,   1, 119, 119,   1,  0,  8'b0000_0000};
        tbl[3]  = '{0, 1, 118,   1,   1, 119, 119,   1,  0,  8'b0000_0000};
        tbl[4]  = '{0, 1, 119,   1,   1, 119, 119,   1,  0,  8'b0000_1000};
        tbl[5]  = '{0, 0,   0,   1,   1, 120, 120,   1,  0,  8'b0000_1000};
        tbl[6]  = '{0, 1, 120,   1,   1, 120, 120,   1,  1,  8'b1001_1001};
        tbl[7]  = '{0, 0,   0,   1,   1, 120, 120,   1,  0,  8'b1001_1000};
        tbl[8]  = '{0, 0,   0,   1,   1, 120, 120,   1,  1,  8'b1000_1000};
        tbl[9]  = '{0, 0,   0,   0,   1, 120, 120,   1,  0,  8'b0000_1000};
        tbl[10] = '{0, 1, 121,   0,   1, 120, 120,   1,  0,  8'b0000_1000};
        tbl[11] = '{0, 1, 123,   0,   1, 120, 120,   1,  0,  8'b0000_0100};
        tbl[12] = '{0, 0,   0,   0,   1, 120, 120,   1,  0,  8'b0000_0000};

        rst = 1; tick = 0; slot = 0; txen = 0; rxen = 0; txs = 0; rxs = 0; msk = 0; clr = 0;
        idle(3);
        chk("reset_outputs", {24'd0, tx_win, rx_win, frame_start, intflag, locked, slip, loss, collide}, 0);
        rst = 0;

        for (int i = 0; i < 13; i++) begin
            rst  = tbl[i].rst;  tick = tbl[i].tick; slot = 8'(tbl[i].slot);
            txen = tbl[i].txen; rxen = tbl[i].rxen;
            txs  = 8'(tbl[i].txs); rxs = 8'(tbl[i].rxs);
            msk  = tbl[i].msk;  clr  = tbl[i].clr;
            cycle();
            chk($sformatf("tbl[%0d]", i),
                {24'd0, tx_win, rx_win, frame_start, intflag, locked, slip, loss, collide},
                {24'd0, tbl[i].exp});
        end
        tick = 0; clr = 0;

        // Acquire lock on slots 0..3; the locking tick opens no window.
        rst = 1; idle(2); rst = 0;
        txen = 1; rxen = 0; txs = 8'd3; msk = 1;
        for (int k = 0; k < 3; k++) begin
            do_tick(k); chk("t1_hunting", locked, 0); idle(19);
        end
        do_tick(3); chk("t1_locked", locked, 1); chk("t1_no_window", tx_win, 0); idle(19);

        // TX window at slot 60, sticky interrupt until cleared.
        txs = 8'd60;
        for (int k = 4; k < 60; k++) begin do_tick(k); idle(3); end
        do_tick(60); chk("t2_tx_open", tx_win, 1); chk("t2_int_set", intflag, 1);
        idle(19);    chk("t2_tx_held", tx_win, 1);
        do_tick(61); chk("t2_tx_closed", tx_win, 0); chk("t2_int_sticky", intflag, 1);
        idle(3);
        clr = 1; cycle(); clr = 0;
        chk("t2_int_cleared", intflag, 0);

        // Frame wrap 254,255,0: one FRAME_START, no SLIP.
        for (int k = 62; k < 254; k++) begin do_tick(k); idle(1); end
        fs_cnt = 0; slip_cnt = 0;
        for (int k = 254; k < 257; k++) begin
            do_tick(k % 256); fs_cnt += int'(frame_start); slip_cnt += int'(slip);
            cycle();          fs_cnt += int'(frame_start); slip_cnt += int'(slip);
        end
        chk("t3_frame_start_once", fs_cnt, 1);
        chk("t3_no_slip", slip_cnt, 0);

        // Slip on 10,11,13 and re-lock on 13,14,15,16.
        for (int k = 1; k < 12; k++) begin do_tick(k); idle(1); end
        do_tick(13); chk("t4_slip", slip, 1); chk("t4_unlocked", locked, 0);
        idle(1);     chk("t4_slip_one_cycle", slip, 0);
        for (int k = 14; k < 16; k++) begin do_tick(k); idle(1); chk("t4_rehunt", locked, 0); end
        do_tick(16); chk("t4_relocked", locked, 1);

        // Tick on the last permitted watchdog cycle keeps lock.
        txs = 8'd18;
        idle(WDOG - 1);
        do_tick(17); chk("wdog_edge_locked", locked, 1); chk("wdog_edge_no_loss", loss, 0);
        do_tick(18); chk("t5_tx_open", tx_win, 1);

        // Stop ticking: LOSS exactly WDOG cycles after the last tick.
        n = 0;
        while (!loss && n < WDOG + 10) begin cycle(); n++; end
        chk("t5_loss_seen", loss, 1);
        chk("t5_loss_latency", n, WDOG);
        chk("t5_windows_closed", {tx_win, rx_win}, 0);
        chk("t5_unlocked", locked, 0);
        idle(5);
        for (int k = 40; k < 43; k++) begin do_tick(k); chk("t5_hunt", locked, 0); idle(2); end
        do_tick(43); chk("t5_relock", locked, 1);

        // Randomized ticks, slips, gaps around the watchdog limit and resets.
        rst = 1; idle(2); rst = 0;
        gs = $urandom_range(0, 255);
        for (int k = 0; k < 600; k++) begin
            r   = $urandom_range(0, 29);
            gap = (r == 0) ? WDOG - 1 + $urandom_range(0, 2) : $urandom_range(1, 6);
            for (int i = 1; i < gap; i++) begin rand_ctl(); cycle(); end
            rand_ctl();
            s    = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 255) : gs;
            txs  = 8'(s + $urandom_range(0, 3));
            rxs  = 8'(s + $urandom_range(0, 3));
            txen = ($urandom_range(0, 3) != 0);
            rxen = ($urandom_range(0, 3) != 0);
            msk  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) rst = 1;
            do_tick(s);
            rst = 0;
            gs  = (s + 1) % 256;
        end
        idle(WDOG + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tpu_slot_tracker
`default_nettype wire
